// File: rtl/fetch_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared widths, NOP encoding and enum types for the fetch
//            controller, its bus interface and its instruction RAM.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0) used for squashed slots.
    localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

    // Controller FSM states; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Source of instruction_EX: reset zero, squash NOP, or RAM read data.
    typedef enum logic [1:0] {
        OUT_ZERO = 2'd0,
        OUT_NOP  = 2'd1,
        OUT_RAM  = 2'd2
    } out_sel_t;

endpackage
`default_nettype wire

// File: rtl/fetch_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller_if
// Brief    : Control, loader and EX-stage signals of the fetch controller.
//            master = environment side, slave = fetch_controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_controller_if;
    import fetch_pkg::*;

    logic              start;
    logic              halt;
    logic              stall_EX;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic [DATA_W-1:0] instruction_EX;
    logic [ADDR_W-1:0] pc_EX;
    logic              valid_EX;
    logic [1:0]        state_o;

    modport master (
        output start, halt, stall_EX, redirect_valid, redirect_pc,
               ld_valid, ld_addr, ld_data,
        input  ld_ready, instruction_EX, pc_EX, valid_EX, state_o
    );

    modport slave (
        input  start, halt, stall_EX, redirect_valid, redirect_pc,
               ld_valid, ld_addr, ld_data,
        output ld_ready, instruction_EX, pc_EX, valid_EX, state_o
    );

endinterface
`default_nettype wire

// File: rtl/fetch_controller_inst_ram.sv
`default_nettype none
// ============================================================================
// Module   : inst_ram
// Brief    : 4096x32 instruction memory, one synchronous write port and one
//            synchronous read port. The controller never enables both.
// Revision : 1.0 - initial release
// ============================================================================
module inst_ram
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_q;

    // Loader write port; contents survive controller reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; holds its last value while re_i is low.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : fetch_controller
// Brief    : IDLE/RUN/HALT instruction fetch unit. Loads the instruction RAM
//            in IDLE, fetches one word per cycle in RUN with stall, redirect
//            and halt handling, and presents a registered instruction to EX.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_controller
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fetch_controller_if.slave  bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_ex_q, pc_ex_d;
    logic              valid_q, valid_d;
    out_sel_t          sel_q, sel_d;

    logic              ram_we;
    logic              ram_re;
    logic              w_idle;
    logic [DATA_W-1:0] ram_rdata;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; halt in RUN wins regardless of stall/redirect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (bus.halt)  state_d = HALT;
            HALT:    if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: loader handshake and debug state.
    always_comb begin
        w_idle       = (state_q == IDLE);
        bus.ld_ready = w_idle;
        bus.state_o  = state_q;
        ram_we       = w_idle && bus.ld_valid;
    end

    // Fetch datapath next-state: redirect/halt squash, then stall, then advance.
    always_comb begin
        pc_d    = pc_q;
        pc_ex_d = pc_ex_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        ram_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pc_d = '0;
                end
            end
            RUN: begin
                if (bus.redirect_valid || bus.halt) begin
                    sel_d   = OUT_NOP;
                    valid_d = 1'b0;
                    if (bus.redirect_valid) begin
                        pc_d = bus.redirect_pc;
                    end
                end else if (!bus.stall_EX) begin
                    ram_re  = 1'b1;
                    sel_d   = OUT_RAM;
                    valid_d = 1'b1;
                    pc_ex_d = pc_q;
                    pc_d    = pc_q + ADDR_W'(1);
                end
            end
            default: ; // HALT keeps the NOP/invalid outputs loaded on entry
        endcase
    end

    // Fetch datapath registers; reset abandons any in-flight fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            pc_ex_q <= '0;
            valid_q <= 1'b0;
            sel_q   <= OUT_ZERO;
        end else begin
            pc_q    <= pc_d;
            pc_ex_q <= pc_ex_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    // EX-stage instruction: the RAM read register is the fetch pipeline stage.
    always_comb begin
        case (sel_q)
            OUT_RAM: bus.instruction_EX = ram_rdata;
            OUT_NOP: bus.instruction_EX = NOP;
            default: bus.instruction_EX = '0;
        endcase
        bus.pc_EX    = pc_ex_q;
        bus.valid_EX = valid_q;
    end

    inst_ram u_inst_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (bus.ld_addr),
        .wdata_i (bus.ld_data),
        .re_i    (ram_re),
        .raddr_i (pc_q),
        .rdata_o (ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_controller
// Brief    : Directed self-checking bench for fetch_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;
    import fetch_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    fetch_controller_if bus ();

    fetch_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.halt = 0; bus.stall_EX = 0; bus.redirect_valid = 0;
        bus.redirect_pc = '0; bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_data = '0;
    endtask

    task automatic load_word(input logic [11:0] a, input logic [31:0] d);
        bus.ld_valid = 1; bus.ld_addr = a; bus.ld_data = d;
        step();
        bus.ld_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #1;
        total++; if (bus.state_o !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", bus.state_o); end
        total++; if (bus.valid_EX !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.valid_EX); end
        total++; if (bus.instruction_EX !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", bus.instruction_EX); end
        total++; if (bus.pc_EX !== 12'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", bus.pc_EX); end
        total++; if (bus.ld_ready !== 1'b1) begin bad++; $display("FAIL rst_ldready got=%b exp=1", bus.ld_ready); end
        step();
        rst = 0;
        step();
    endtask

    task automatic test_load_run();
        logic [31:0] exp_i;
        for (int i = 0; i < 8; i++) load_word(12'(i), 32'hA0 + 32'(i));
        for (int i = 0; i < 3; i++) load_word(12'h100 + 12'(i), 32'hB0 + 32'(i));
        bus.start = 1;
        step();
        bus.start = 0;
        total++; if (bus.state_o !== 2'd1) begin bad++; $display("FAIL start_state got=%0d exp=1", bus.state_o); end
        total++; if (bus.valid_EX !== 1'b0) begin bad++; $display("FAIL start_valid got=%b exp=0", bus.valid_EX); end
        total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL run_ldready got=%b exp=0", bus.ld_ready); end
        for (int i = 0; i < 5; i++) begin
            step();
            exp_i = 32'hA0 + 32'(i);
            total++; if (bus.instruction_EX !== exp_i) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, bus.instruction_EX, exp_i); end
            total++; if (bus.pc_EX !== 12'(i)) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pc_EX, i); end
            total++; if (bus.valid_EX !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, bus.valid_EX); end
        end
    endtask

    task automatic test_stall();
        bus.stall_EX = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.instruction_EX !== 32'hA4) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=a4", i, bus.instruction_EX); end
            total++; if (bus.pc_EX !== 12'd4) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=4", i, bus.pc_EX); end
            total++; if (bus.valid_EX !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, bus.valid_EX); end
        end
        bus.stall_EX = 0;
        step();
        total++; if (bus.pc_EX !== 12'd5) begin bad++; $display("FAIL resume_pc got=%h exp=5", bus.pc_EX); end
        total++; if (bus.instruction_EX !== 32'hA5) begin bad++; $display("FAIL resume_instr got=%h exp=a5", bus.instruction_EX); end
    endtask

    task automatic test_redirect_ld_in_run();
        bus.redirect_valid = 1; bus.redirect_pc = 12'h100; bus.stall_EX = 1;
        step();
        bus.redirect_valid = 0; bus.stall_EX = 0;
        total++; if (bus.valid_EX !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", bus.valid_EX); end
        total++; if (bus.instruction_EX !== NOP) begin bad++; $display("FAIL redir_instr got=%h exp=%h", bus.instruction_EX, NOP); end
        step();
        total++; if (bus.pc_EX !== 12'h100) begin bad++; $display("FAIL redir_pc got=%h exp=100", bus.pc_EX); end
        total++; if (bus.valid_EX !== 1'b1) begin bad++; $display("FAIL redir_valid2 got=%b exp=1", bus.valid_EX); end
        total++; if (bus.instruction_EX !== 32'hB0) begin bad++; $display("FAIL redir_instr2 got=%h exp=b0", bus.instruction_EX); end
        // loader request while running must be refused
        bus.ld_valid = 1; bus.ld_addr = 12'h0; bus.ld_data = 32'hDEAD;
        #1;
        total++; if (bus.ld_ready !== 1'b0) begin bad++; $display("FAIL ld_in_run_ready got=%b exp=0", bus.ld_ready); end
        step();
        bus.ld_valid = 0;
        total++; if (bus.pc_EX !== 12'h101) begin bad++; $display("FAIL redir_pc3 got=%h exp=101", bus.pc_EX); end
    endtask

    task automatic test_halt_resume();
        bus.halt = 1;
        step();
        bus.halt = 0;
        total++; if (bus.state_o !== 2'd2) begin bad++; $display("FAIL halt_state got=%0d exp=2", bus.state_o); end
        total++; if (bus.instruction_EX !== NOP) begin bad++; $display("FAIL halt_instr got=%h exp=%h", bus.instruction_EX, NOP); end
        // redirect, stall and loader are all ignored while halted
        bus.redirect_valid = 1; bus.redirect_pc = 12'h200; bus.stall_EX = 1;
        bus.ld_valid = 1; bus.ld_addr = 12'h0; bus.ld_data = 32'hDEAD;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (bus.valid_EX !== 1'b0) begin bad++; $display("FAIL halt_valid[%0d] got=%b exp=0", i, bus.valid_EX); end
        end
        idle_inputs();
        bus.start = 1;
        step();
        bus.start = 0;
        total++; if (bus.state_o !== 2'd1) begin bad++; $display("FAIL resume_state got=%0d exp=1", bus.state_o); end
        step();
        total++; if (bus.pc_EX !== 12'h102) begin bad++; $display("FAIL halt_resume_pc got=%h exp=102", bus.pc_EX); end
        total++; if (bus.instruction_EX !== 32'hB2) begin bad++; $display("FAIL halt_resume_instr got=%h exp=b2", bus.instruction_EX); end
        total++; if (bus.valid_EX !== 1'b1) begin bad++; $display("FAIL halt_resume_valid got=%b exp=1", bus.valid_EX); end
        step();
        // asynchronous reset mid-RUN, checked before any clock edge
        rst = 1;
        #1;
        total++; if (bus.state_o !== 2'd0) begin bad++; $display("FAIL async_rst_state got=%0d exp=0", bus.state_o); end
        total++; if (bus.valid_EX !== 1'b0) begin bad++; $display("FAIL async_rst_valid got=%b exp=0", bus.valid_EX); end
        step();
        rst = 0;
        step();
    endtask

    task automatic test_ram_kept();
        bus.start = 1;
        step();
        bus.start = 0;
        step();
        total++; if (bus.instruction_EX !== 32'hA0) begin bad++; $display("FAIL ram0_kept got=%h exp=a0", bus.instruction_EX); end
        do_reset();
    endtask

    task automatic test_wrap();
        load_word(12'hFFF, 32'hFF);
        load_word(12'h000, 32'h11);
        bus.start = 1;
        step();
        bus.start = 0;
        step();
        bus.redirect_valid = 1; bus.redirect_pc = 12'hFFF;
        step();
        bus.redirect_valid = 0;
        step();
        total++; if (bus.pc_EX !== 12'hFFF) begin bad++; $display("FAIL wrap_pc_hi got=%h exp=fff", bus.pc_EX); end
        total++; if (bus.instruction_EX !== 32'hFF) begin bad++; $display("FAIL wrap_instr_hi got=%h exp=ff", bus.instruction_EX); end
        step();
        total++; if (bus.pc_EX !== 12'h000) begin bad++; $display("FAIL wrap_pc_lo got=%h exp=0", bus.pc_EX); end
        total++; if (bus.instruction_EX !== 32'h11) begin bad++; $display("FAIL wrap_instr_lo got=%h exp=11", bus.instruction_EX); end
        total++; if (bus.valid_EX !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", bus.valid_EX); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1;
        idle_inputs();
        test_reset();
        test_load_run();
        test_stall();
        test_redirect_ld_in_run();
        test_halt_resume();
        test_ram_kept();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset; forces all state to reset values immediately on assertion.
REQ-003 start  input  1  level, sampled in IDLE/HALT; begins or resumes execution.
REQ-004 halt  input  1  level, sampled in RUN; stops fetch.
REQ-005 stall_EX  input  1  EX not ready; hold PC and EX outputs.
REQ-006 redirect_valid  input  1  taken branch/jump from EX.
REQ-007 redirect_pc  input  12  word address of redirect target.
REQ-008 ld_valid  input  1  loader write request into instruction RAM.
REQ-009 ld_addr  input  12  loader word address.
REQ-010 ld_data  input  32  loader write data.
REQ-011 ld_ready  output  1  loader write accepted this cycle; equals (state==IDLE).
REQ-012 instruction_EX  output  32  registered instruction presented to EX.
REQ-013 pc_EX  output  12  word address of instruction_EX.
REQ-014 valid_EX  output  1  instruction_EX is a real, non-squashed instruction.
REQ-015 state_o  output  2  current FSM state, for debug.

Function
REQ-016 FSM states SHALL be IDLE, RUN, HALT; encoding IDLE=0, RUN=1, HALT=2.
REQ-017 IDLE: ld_ready=1; ld_valid writes ld_data to RAM[ld_addr] at the clock edge; no fetch; valid_EX=0.
REQ-018 IDLE->RUN on start; PC_FETCH set to 0 on that edge; a simultaneous ld_valid write still completes.
REQ-019 RUN, no stall/redirect/halt: each edge instruction_EX<=RAM[PC_FETCH], pc_EX<=PC_FETCH, valid_EX<=1, PC_FETCH<=PC_FETCH+1.
REQ-020 Fetch latency: exactly one cycle from PC_FETCH to instruction_EX; RAM read is synchronous.
REQ-021 PC_FETCH arithmetic is 12-bit modulo; 4095+1 wraps to 0 with no other effect.
REQ-022 stall_EX=1 in RUN (no redirect): PC_FETCH, instruction_EX, pc_EX, valid_EX all hold.
REQ-023 redirect_valid=1 in RUN: PC_FETCH<=redirect_pc, instruction_EX<=NOP (32'h00000013), valid_EX<=0; next edge fetches from redirect_pc.
REQ-024 Priority in RUN: redirect_valid > stall_EX > normal advance; halt is evaluated in parallel with all of these.
REQ-025 RUN->HALT on halt: that edge loads instruction_EX<=NOP, valid_EX<=0, PC_FETCH unchanged unless redirect_valid is also 1, in which case PC_FETCH<=redirect_pc.
REQ-026 HALT: no fetch; outputs hold NOP/valid_EX=0; start resumes RUN at current PC_FETCH.
REQ-027 ld_valid outside IDLE SHALL be ignored (ld_ready=0, RAM unchanged).
REQ-028 redirect_valid and stall_EX outside RUN SHALL be ignored.

Reset
REQ-029 On rst: state=IDLE, PC_FETCH=0, instruction_EX=32'h0, pc_EX=0, valid_EX=0, ld_ready=1 (follows state).
REQ-030 Reset mid-RUN SHALL abandon in-flight fetch; RAM contents are NOT cleared by reset.

Structure
REQ-031 Package fetch_pkg SHALL hold ADDR_W=12, DATA_W=32, NOP constant, and the state enum type.
REQ-032 Sub-module inst_ram: 4096x32, one synchronous read port, one synchronous write port; controller owns arbitration (write only in IDLE, read only in RUN), so no port conflict exists.

Verification
REQ-033 Load RAM[0..3]=0xA0,0xA1,0xA2,0xA3 in IDLE, pulse start -> instruction_EX sequence 0xA0..0xA3 on cycles 2..5 after start edge, pc_EX 0..3, valid_EX=1.
REQ-034 RUN at PC_FETCH=5, stall_EX high 3 cycles -> instruction_EX/pc_EX frozen 3 cycles, then resume with pc_EX=5.
REQ-035 redirect_valid with redirect_pc=0x100 and stall_EX=1 same cycle -> next cycle valid_EX=0, instruction_EX=0x00000013; following cycle pc_EX=0x100, valid_EX=1.
REQ-036 Preload RAM[4095]=0xFF, RAM[0]=0x11, redirect to 4095 -> pc_EX 4095 then 0, instruction_EX 0xFF then 0x11.
REQ-037 ld_valid during RUN to addr 0 with data 0xDEAD -> ld_ready=0, RAM[0] unchanged after return to IDLE via rst.
REQ-038 halt in RUN, then start -> valid_EX=0 during HALT, fetch resumes at saved PC_FETCH; rst mid-RUN -> state_o=0, valid_EX=0 immediately without a clock edge.
